// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage data-bus engine.
package mem_access_pkg;

  typedef logic [31:0] InstAddr_t;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2
  } MemSize_t;

  localparam logic [4:0] ExcAdel = 5'h04;
  localparam logic [4:0] ExcAdes = 5'h05;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } RegWriteReq_t;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign_ext;
  } MemAccessReq_t;

  typedef struct packed {
    logic        occur;
    logic [4:0]  code;
    InstAddr_t   pc;
    logic [31:0] badvaddr;
  } ExceptInfo_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic stall_wb;
  } Stall_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrain,
    StDone
  } MemAccState_t;

  // Size encoding 3 has no legal alignment and is reported as misaligned.
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      MemByte: ok = 1'b1;
      MemHalf: ok = ~addr_lo[0];
      MemWord: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / data replication and load extract / extend.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  st_addr_lo_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_sign_ext_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: enables follow the addressed lane, data is replicated to every lane.
  always_comb begin
    st_be_o    = 4'hF;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      MemByte: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      MemHalf: begin
        st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'hF;
        st_wdata_o = st_wdata_i;
      end
    endcase
  end

  // Load side: little-endian lane select followed by zero/sign extension.
  always_comb begin
    ld_byte = 8'h00;
    case (ld_addr_lo_i)
      2'b00:   ld_byte = ld_rdata_i[7:0];
      2'b01:   ld_byte = ld_rdata_i[15:8];
      2'b10:   ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_size_i)
      MemByte: ld_data_o = {{24{ld_sign_ext_i & ld_byte[7]}}, ld_byte};
      MemHalf: ld_data_o = {{16{ld_sign_ext_i & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-bus engine: one req/ack access per load/store, alignment
// exceptions, pipeline stall while outstanding, load data merged into writeback.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  InstAddr_t             mem_pc,
  input  RegWriteReq_t          mem_reg_wr,
  input  MemAccessReq_t         mem_memory_req,
  input  ExceptInfo_t           mem_except,
  input  Stall_t                stall,
  input  logic                  flush,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [31:0]           dbus_addr,
  output logic [3:0]            dbus_be,
  output logic [31:0]           dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [31:0]           dbus_rdata,
  output RegWriteReq_t          wb_reg_wr,
  output ExceptInfo_t           wb_except,
  output logic                  stall_req,
  output logic [PERF_WIDTH-1:0] perf_stall_cyc
);

  MemAccState_t state_q, state_d;
  logic                  dbus_req_q, dbus_req_d;
  logic                  dbus_we_q, dbus_we_d;
  logic [31:0]           dbus_addr_q, dbus_addr_d;
  logic [3:0]            dbus_be_q, dbus_be_d;
  logic [31:0]           dbus_wdata_q, dbus_wdata_d;
  logic [1:0]            ld_addr_lo_q, ld_addr_lo_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_sign_ext_q, ld_sign_ext_d;
  logic [31:0]           result_q, result_d;
  logic [PERF_WIDTH-1:0] perf_q, perf_d;

  logic        aligned, misaligned, access;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  // Only stall_wb matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall.stall_if, stall.stall_id, stall.stall_ex, stall.stall_mem};

  assign aligned    = addr_aligned(mem_memory_req.size, mem_memory_req.addr[1:0]);
  assign misaligned = mem_memory_req.ce & ~mem_except.occur & ~aligned;
  assign access     = mem_memory_req.ce & ~mem_except.occur & aligned & ~flush;

  mem_lane_align u_lane_align (
    .st_addr_lo_i  (mem_memory_req.addr[1:0]),
    .st_size_i     (mem_memory_req.size),
    .st_wdata_i    (mem_memory_req.wdata),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_addr_lo_i  (ld_addr_lo_q),
    .ld_size_i     (ld_size_q),
    .ld_sign_ext_i (ld_sign_ext_q),
    .ld_rdata_i    (dbus_rdata),
    .ld_data_o     (ld_data)
  );

  // Access FSM: next state, bus register loads and writeback outputs.
  always_comb begin
    state_d       = state_q;
    dbus_req_d    = dbus_req_q;
    dbus_we_d     = dbus_we_q;
    dbus_addr_d   = dbus_addr_q;
    dbus_be_d     = dbus_be_q;
    dbus_wdata_d  = dbus_wdata_q;
    ld_addr_lo_d  = ld_addr_lo_q;
    ld_size_d     = ld_size_q;
    ld_sign_ext_d = ld_sign_ext_q;
    result_d      = result_q;
    stall_req     = 1'b0;
    wb_reg_wr     = mem_reg_wr;
    wb_except     = mem_except;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          stall_req     = 1'b1;
          dbus_req_d    = 1'b1;
          dbus_we_d     = mem_memory_req.we;
          dbus_addr_d   = {mem_memory_req.addr[31:2], 2'b00};
          dbus_be_d     = st_be;
          dbus_wdata_d  = st_wdata;
          ld_addr_lo_d  = mem_memory_req.addr[1:0];
          ld_size_d     = mem_memory_req.size;
          ld_sign_ext_d = mem_memory_req.sign_ext;
          state_d       = StWait;
        end
      end
      StWait: begin
        stall_req    = 1'b1;
        wb_reg_wr.we = 1'b0;
        if (dbus_ack) begin
          dbus_req_d = 1'b0;
          if (flush) begin
            state_d = StIdle;
          end else begin
            if (!dbus_we_q) result_d = ld_data;
            state_d = StDone;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Killed access: keep the handshake alive until the slave finishes.
        stall_req    = 1'b1;
        wb_reg_wr.we = 1'b0;
        if (dbus_ack) begin
          dbus_req_d = 1'b0;
          state_d    = StIdle;
        end
      end
      StDone: begin
        wb_reg_wr.wdata = dbus_we_q ? mem_reg_wr.wdata : result_q;
        if (!stall.stall_wb || flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (misaligned) begin
      wb_reg_wr.we       = 1'b0;
      wb_except.occur    = 1'b1;
      wb_except.code     = mem_memory_req.we ? ExcAdes : ExcAdel;
      wb_except.pc       = mem_pc;
      wb_except.badvaddr = mem_memory_req.addr;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    perf_d = perf_q;
    if (stall_req && (perf_q != '1)) perf_d = perf_q + PERF_WIDTH'(1);
  end

  // State and bus registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      dbus_req_q    <= 1'b0;
      dbus_we_q     <= 1'b0;
      dbus_addr_q   <= '0;
      dbus_be_q     <= '0;
      dbus_wdata_q  <= '0;
      ld_addr_lo_q  <= '0;
      ld_size_q     <= '0;
      ld_sign_ext_q <= 1'b0;
      result_q      <= '0;
      perf_q        <= '0;
    end else begin
      state_q       <= state_d;
      dbus_req_q    <= dbus_req_d;
      dbus_we_q     <= dbus_we_d;
      dbus_addr_q   <= dbus_addr_d;
      dbus_be_q     <= dbus_be_d;
      dbus_wdata_q  <= dbus_wdata_d;
      ld_addr_lo_q  <= ld_addr_lo_d;
      ld_size_q     <= ld_size_d;
      ld_sign_ext_q <= ld_sign_ext_d;
      result_q      <= result_d;
      perf_q        <= perf_d;
    end
  end

  assign dbus_req       = dbus_req_q;
  assign dbus_we        = dbus_we_q;
  assign dbus_addr      = dbus_addr_q;
  assign dbus_be        = dbus_be_q;
  assign dbus_wdata     = dbus_wdata_q;
  assign perf_stall_cyc = perf_q;

endmodule
